// File: rtl/mips32_muldiv_if.sv
// Pipeline-to-muldiv bus: operation issue, MTHI/MTLO writes, status and HI/LO.
interface mips32_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            mthi_we;
  logic            mtlo_we;
  logic [XLEN-1:0] wdata;
  logic            ready;
  logic            busy;
  logic            done;
  logic            dz;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, flush, mthi_we, mtlo_we, wdata,
    input  ready, busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, mthi_we, mtlo_we, wdata,
    output ready, busy, done, dz, hi, lo
  );
endinterface

// File: rtl/mips32_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, one bit per cycle.
module mips32_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input logic            clk,
  input logic            rst,
  mips32_muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   opa_q;      // |a|: multiplicand
  logic [XLEN-1:0]   opb_q;      // |b|: divisor
  logic [XLEN-1:0]   a_raw_q;    // raw dividend for the divide-by-zero HI value
  logic [2*XLEN-1:0] acc_q;      // product accumulator; low half doubles as quotient
  logic [XLEN:0]     rem_q;      // partial remainder
  logic              neg_q;      // negate product / quotient
  logic              neg_rem_q;  // negate remainder
  logic              bz_q;       // divide with zero divisor
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              dz_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_d;
  logic [XLEN+1:0]   div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [XLEN:0]     div_rem_d;
  logic [XLEN-1:0]   div_quo_d;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;
  logic              is_signed_in;
  logic              accept;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  assign is_signed_in = ~bus.op[0];
  assign accept       = (state_q == IDLE) && bus.start && !bus.flush;

  // One iteration of shift-add multiply and restoring divide, plus sign fix-up of the final value.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};

    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {2'b00, opb_q};
    if (div_diff[XLEN+1]) begin
      div_rem_d = div_shift[XLEN:0];
      div_quo_d = {acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_rem_d = div_diff[XLEN:0];
      div_quo_d = {acc_q[XLEN-2:0], 1'b1};
    end

    prod_fix = neg_q ? -mul_acc_d : mul_acc_d;
    quo_fix  = bz_q ? '1 : (neg_q ? -div_quo_d : div_quo_d);
    rem_fix  = bz_q ? a_raw_q : (neg_rem_q ? -div_rem_d[XLEN-1:0] : div_rem_d[XLEN-1:0]);

    res_hi = op_q[1] ? rem_fix : prod_fix[2*XLEN-1:XLEN];
    res_lo = op_q[1] ? quo_fix : prod_fix[XLEN-1:0];
  end

  // Control FSM, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      a_raw_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bz_q      <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.mthi_we) hi_q <= bus.wdata;
          if (bus.mtlo_we) lo_q <= bus.wdata;
          if (accept) begin
            op_q      <= bus.op;
            opa_q     <= abs_val(bus.a, is_signed_in);
            opb_q     <= abs_val(bus.b, is_signed_in);
            a_raw_q   <= bus.a;
            acc_q     <= {{XLEN{1'b0}}, bus.op[1] ? abs_val(bus.a, is_signed_in)
                                                  : abs_val(bus.b, is_signed_in)};
            rem_q     <= '0;
            neg_q     <= is_signed_in && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            neg_rem_q <= is_signed_in && bus.a[XLEN-1];
            bz_q      <= bus.op[1] && (bus.b == '0);
            cnt_q     <= CW'(XLEN - 1);
            state_q   <= RUN;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            if (op_q[1]) begin
              acc_q <= {acc_q[2*XLEN-1:XLEN], div_quo_d};
              rem_q <= div_rem_d;
            end else begin
              acc_q <= mul_acc_d;
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              done_q  <= 1'b1;
              dz_q    <= bz_q;
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dz    = dz_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mips32_muldiv.sv
// Randomized scoreboard bench for mips32_muldiv against an arithmetic reference model.
module tb_mips32_muldiv;
  localparam int unsigned XLEN = 32;
  localparam int LAT = XLEN + 1;  // driving negedge to done-visible negedge

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  logic prev_done = 1'b0;

  mips32_muldiv_if #(.XLEN(XLEN)) intf ();

  mips32_muldiv #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference: MIPS semantics with plain 64-bit / C-style integer arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    int          sa, sb;
    e.dz  = 1'b0;
    e.cyc = 0;
    case (op)
      2'd0: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      2'd1: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
        end else if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else if (op == 2'd2) begin
          sa = int'(a); sb = int'(b);
          e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    int   n = 0;
    while (!intf.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!intf.ready) fail_now("issue_wait_ready");
    intf.start = 1'b1;
    intf.op    = op;
    intf.a     = a;
    intf.b     = b;
    if (push) begin
      e     = model(op, a, b);
      e.cyc = cyc + LAT;
      sb_q.push_back(e);
    end
    @(negedge clk);
    intf.start = 1'b0;
    intf.op    = 2'($urandom_range(0, 3));
    intf.a     = $urandom;
    intf.b     = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(sb_q.size() == 0 && intf.ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("wait_idle");
  endtask

  // Monitor: compares every done against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (intf.busy === intf.ready) chk("busy_eq_not_ready", {63'd0, intf.busy}, {63'd0, ~intf.ready});
      if (intf.done) begin
        if (prev_done) chk("done_single_cycle", 64'd1, 64'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("hi", {32'd0, intf.hi}, {32'd0, e.hi});
          chk("lo", {32'd0, intf.lo}, {32'd0, e.lo});
          chk("dz", {63'd0, intf.dz}, {63'd0, e.dz});
          chk("latency", 64'(cyc), 64'(e.cyc));
          chk("ready_with_done", {63'd0, intf.ready}, 64'd1);
        end
      end else if (intf.dz) begin
        chk("dz_without_done", 64'd1, 64'd0);
      end
      prev_done = intf.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    logic [31:0] hold_hi, hold_lo, ra, rb;
    logic [1:0]  rop;
    intf.start = 1'b0; intf.op = 2'd0; intf.a = '0; intf.b = '0;
    intf.flush = 1'b0; intf.mthi_we = 1'b0; intf.mtlo_we = 1'b0; intf.wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, intf.ready}, 64'd1);
    chk("rst_busy",  {63'd0, intf.busy},  64'd0);
    chk("rst_done",  {63'd0, intf.done},  64'd0);
    chk("rst_hilo",  {intf.hi, intf.lo},  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed test-plan operations, with spot checks of the literal results
    issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_idle();
    chk("mult_neg3x7", {intf.hi, intf.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(2'd3, 32'd7, 32'd2, 1'b1);
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_idle();
    chk("div_7_neg2", {intf.hi, intf.lo}, {32'd1, 32'hFFFF_FFFD});
    issue(2'd2, 32'd5, 32'd0, 1'b1);
    wait_idle();
    chk("div_by_zero", {intf.hi, intf.lo}, {32'd5, 32'hFFFF_FFFF});
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    chk("div_overflow", {intf.hi, intf.lo}, {32'd0, 32'h8000_0000});

    // MTHI / MTLO in IDLE
    intf.mthi_we = 1'b1; intf.wdata = 32'h1234;
    @(negedge clk);
    intf.mthi_we = 1'b0; intf.mtlo_we = 1'b1; intf.wdata = 32'h5678;
    chk("mthi_idle", {32'd0, intf.hi}, 64'h1234);
    @(negedge clk);
    intf.mtlo_we = 1'b0;
    chk("mtlo_idle", {32'd0, intf.lo}, 64'h5678);

    // start and MTHI while busy are ignored
    issue(2'd1, 32'd3, 32'd5, 1'b1);
    repeat (3) begin
      intf.start = 1'b1; intf.op = 2'd3; intf.a = 32'd99; intf.b = 32'd4;
      intf.mthi_we = 1'b1; intf.wdata = 32'hDEAD;
      @(negedge clk);
      chk("mthi_busy_ignored", {32'd0, intf.hi}, 64'h1234);
    end
    intf.start = 1'b0; intf.mthi_we = 1'b0;
    wait_idle();

    // Flush in RUN cycle 10
    hold_hi = intf.hi; hold_lo = intf.lo;
    issue(2'd0, 32'd12345, 32'd678, 1'b0);
    repeat (9) @(negedge clk);
    intf.flush = 1'b1;
    @(negedge clk);
    intf.flush = 1'b0;
    chk("flush_ready", {63'd0, intf.ready}, 64'd1);
    repeat (40) @(negedge clk);
    chk("flush_hilo_kept", {intf.hi, intf.lo}, {hold_hi, hold_lo});
    issue(2'd3, 32'd100, 32'd7, 1'b1);
    wait_idle();
    chk("divu_100_7", {intf.hi, intf.lo}, {32'd2, 32'd14});

    // Flush in IDLE blocks start but MTLO applies
    intf.flush = 1'b1; intf.start = 1'b1; intf.op = 2'd1; intf.a = 32'd2; intf.b = 32'd3;
    intf.mtlo_we = 1'b1; intf.wdata = 32'hABCD;
    @(negedge clk);
    intf.flush = 1'b0; intf.start = 1'b0; intf.mtlo_we = 1'b0;
    chk("idle_flush_blocks", {63'd0, intf.ready}, 64'd1);
    chk("idle_flush_mtlo", {32'd0, intf.lo}, 64'hABCD);

    // Randomized back-to-back operations
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 9);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb, 1'b1);
    end
    wait_idle();

    // Reset mid-RUN
    issue(2'd1, 32'hFFFF_0000, 32'h0001_FFFF, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_ready", {63'd0, intf.ready}, 64'd1);
    chk("async_rst_busy",  {63'd0, intf.busy},  64'd0);
    chk("async_rst_hilo",  {intf.hi, intf.lo},  64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", {intf.hi, intf.lo}, 64'd0);
    issue(2'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
